w_fetch_seq: RTL and testbench

//  Sequences one full pass over a neuron's weight memory (1-cycle synchronous read, read-enable gated).

---
 rtl/fnn_pkg.sv | 24 ++
 rtl/pair_fifo2.sv | 78 +++++++
 rtl/w_fetch_seq.sv | 149 ++++++++++++++
 tb/tb_w_fetch_seq.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fnn_pkg.sv
// ---------------------------------------------------------------------------
// fnn_pkg
//   Shared types for the neuron weight-fetch path.
//   fetch_state_t : phases of one pass over a neuron's weight memory
//   DATA_W        : width of weights and activations
//   wa_pair_t     : one (weight, activation, last) pair as seen by the MAC
// ---------------------------------------------------------------------------
package fnn_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_DRAIN
    } fetch_state_t;

    localparam int DATA_W = 16;

    typedef struct packed {
        logic [DATA_W-1:0] w;
        logic [DATA_W-1:0] a;
        logic              last;
    } wa_pair_t;

endpackage

// File: rtl/pair_fifo2.sv
// ---------------------------------------------------------------------------
// pair_fifo2
//   Two-entry FIFO of wa_pair_t used to absorb MAC back-pressure.
//   Ports:
//     clk, rst   : clock, asynchronous active-high reset
//     push, pop  : write din / drop head (simultaneous push and pop allowed)
//     din, dout  : entry written / current head entry
//     count      : number of stored entries (0..2)
//     empty,full : count == 0 / count == 2
// ---------------------------------------------------------------------------
module pair_fifo2
    import fnn_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  logic       pop,
    input  wa_pair_t   din,
    output wa_pair_t   dout,
    output logic [1:0] count,
    output logic       empty,
    output logic       full
);

    wa_pair_t   mem_q [2];
    wa_pair_t   mem_d [2];
    logic       rd_ptr_q, rd_ptr_d;
    logic       wr_ptr_q, wr_ptr_d;
    logic [1:0] count_q, count_d;
    logic       do_push, do_pop;

    // Next-state logic. A push into a full FIFO is only honoured when the
    // head leaves in the same cycle, so storage can never be overrun.
    always_comb begin
        do_pop   = pop && (count_q != 2'd0);
        do_push  = push && ((count_q != 2'd2) || do_pop);
        mem_d[0] = mem_q[0];
        mem_d[1] = mem_q[1];
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = din;
            wr_ptr_d        = ~wr_ptr_q;
        end
        if (do_pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    // Storage and pointer registers; reset leaves the FIFO empty and zeroed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            mem_q[0] <= mem_d[0];
            mem_q[1] <= mem_d[1];
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    assign dout  = mem_q[rd_ptr_q];
    assign count = count_q;
    assign empty = (count_q == 2'd0);
    assign full  = (count_q == 2'd2);

endmodule

// File: rtl/w_fetch_seq.sv
// ---------------------------------------------------------------------------
// w_fetch_seq
//   Walks once over a neuron's weight memory per pass, pairing each weight
//   with the matching incoming activation and handing (weight, act, last)
//   to the MAC. Valid/ready on both sides with full back-pressure.
//   Ports:
//     clk, rst             : clock, asynchronous active-high reset
//     start                : begin a pass (only looked at while idle)
//     busy, done           : pass in progress / one-cycle end-of-pass pulse
//     in_valid/ready/data  : activation stream
//     rom_ren/radd/rdata   : weight memory, 1-cycle synchronous read
//     out_valid/ready      : pair handshake towards the MAC
//     out_weight/act/last  : pair contents, last marks index numWeight-1
// ---------------------------------------------------------------------------
module w_fetch_seq
    import fnn_pkg::*;
#(
    parameter int numWeight    = 30,
    parameter int addressWidth = (numWeight > 1) ? $clog2(numWeight) : 1,
    parameter int dataWidth    = DATA_W
)(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    output logic                    busy,
    output logic                    done,
    input  logic                    in_valid,
    input  logic [dataWidth-1:0]    in_data,
    output logic                    in_ready,
    output logic                    rom_ren,
    output logic [addressWidth-1:0] rom_radd,
    input  logic [dataWidth-1:0]    rom_rdata,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [dataWidth-1:0]    out_weight,
    output logic [dataWidth-1:0]    out_act,
    output logic                    out_last
);

    localparam logic [addressWidth-1:0] LAST_ADDR = addressWidth'(numWeight - 1);

    fetch_state_t            state_q, state_d;
    logic [addressWidth-1:0] addr_q, addr_d;
    logic [addressWidth-1:0] radd_hold_q, radd_hold_d;
    logic                    inflight_q, inflight_d;
    logic                    last_q, last_d;
    logic [dataWidth-1:0]    act_q, act_d;

    logic                    fifo_push, fifo_pop;
    logic                    fifo_empty, fifo_full;
    logic [1:0]              fifo_count;
    wa_pair_t                fifo_dout, incoming, head;
    logic                    accept, room;

    pair_fifo2 u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .din   (incoming),
        .dout  (fifo_dout),
        .count (fifo_count),
        .empty (fifo_empty),
        .full  (fifo_full)
    );

    // Handshake and datapath steering. The pair whose weight is arriving
    // from memory this cycle bypasses the FIFO when the FIFO is empty, which
    // gives one cycle of latency and lets 1 pair/cycle flow when the MAC is
    // ready. Room for a new read means fifo_count + inflight < 2, written
    // here in terms of full so the read is refused before storage runs out.
    always_comb begin
        room          = !fifo_full && !((fifo_count == 2'd1) && inflight_q);
        in_ready      = (state_q == S_FETCH) && room;
        accept        = in_valid && in_ready;
        rom_ren       = accept;
        rom_radd      = accept ? addr_q : radd_hold_q;
        incoming.w    = rom_rdata;
        incoming.a    = act_q;
        incoming.last = last_q;
        head          = fifo_empty ? incoming : fifo_dout;
        out_valid     = inflight_q || !fifo_empty;
        out_weight    = out_valid ? head.w : '0;
        out_act       = out_valid ? head.a : '0;
        out_last      = out_valid ? head.last : 1'b0;
        fifo_pop      = !fifo_empty && out_ready;
        fifo_push     = inflight_q && !(fifo_empty && out_ready);
        busy          = (state_q != S_IDLE);
        done          = (state_q == S_DRAIN) && fifo_empty && !inflight_q;
    end

    // Pass sequencing. The activation is captured alongside the memory read
    // so both halves of the pair line up in the following cycle. The address
    // stops at the last index instead of wrapping.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        radd_hold_d = radd_hold_q;
        act_d       = act_q;
        last_d      = last_q;
        inflight_d  = accept;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    addr_d  = '0;
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                if (accept) begin
                    act_d       = in_data;
                    last_d      = (addr_q == LAST_ADDR);
                    radd_hold_d = addr_q;
                    if (addr_q == LAST_ADDR) begin
                        state_d = S_DRAIN;
                    end else begin
                        addr_d = addr_q + addressWidth'(1);
                    end
                end
            end
            S_DRAIN: begin
                if (done) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Sequencer registers; reset aborts any pass with nothing in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            radd_hold_q <= '0;
            act_q       <= '0;
            last_q      <= 1'b0;
            inflight_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            radd_hold_q <= radd_hold_d;
            act_q       <= act_d;
            last_q      <= last_d;
            inflight_q  <= inflight_d;
        end
    end

endmodule

// File: tb/tb_w_fetch_seq.sv
// Self-checking bench for w_fetch_seq: a high-level model tracks accepted
// and delivered pairs, a scoreboard queue holds the expected pairs.
module tb_w_fetch_seq;

   localparam int NW = 30;

   typedef struct {
      logic [15:0] w;
      logic [15:0] a;
      logic        last;
   } exp_t;

   logic        clk;
   logic        rst;
   logic        start, busy, done;
   logic        in_valid, in_ready;
   logic [15:0] in_data;
   logic        rom_ren;
   logic [4:0]  rom_radd;
   logic [15:0] rom_rdata;
   logic        out_valid, out_ready, out_last;
   logic [15:0] out_weight, out_act;

   logic        start1, busy1, done1;
   logic        in_valid1, in_ready1;
   logic [15:0] in_data1;
   logic        rom_ren1;
   logic [0:0]  rom_radd1;
   logic [15:0] rom_rdata1;
   logic        out_valid1, out_ready1, out_last1;
   logic [15:0] out_weight1, out_act1;

   logic [15:0] mem [NW];
   exp_t        exp_q [$];

   int checks = 0;
   int errors = 0;

   int m_active = 0;
   int m_acc = 0;
   int m_taken = 0;
   int done_count = 0;
   int dut_done_count = 0;
   int dut_last_count = 0;

   w_fetch_seq #(.numWeight(NW)) u_dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .busy       (busy),
      .done       (done),
      .in_valid   (in_valid),
      .in_data    (in_data),
      .in_ready   (in_ready),
      .rom_ren    (rom_ren),
      .rom_radd   (rom_radd),
      .rom_rdata  (rom_rdata),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_weight (out_weight),
      .out_act    (out_act),
      .out_last   (out_last)
   );

   w_fetch_seq #(.numWeight(1)) u_dut1 (
      .clk        (clk),
      .rst        (rst),
      .start      (start1),
      .busy       (busy1),
      .done       (done1),
      .in_valid   (in_valid1),
      .in_data    (in_data1),
      .in_ready   (in_ready1),
      .rom_ren    (rom_ren1),
      .rom_radd   (rom_radd1),
      .rom_rdata  (rom_rdata1),
      .out_valid  (out_valid1),
      .out_ready  (out_ready1),
      .out_weight (out_weight1),
      .out_act    (out_act1),
      .out_last   (out_last1)
   );

   // Free-running clock, 10 time units per cycle.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Weight memories with a 1-cycle synchronous, read-enable gated read.
   always @(posedge clk) begin
      if (rom_ren) rom_rdata <= mem[rom_radd];
      if (rom_ren1) rom_rdata1 <= (rom_radd1 == 1'b0) ? 16'h55AA : 16'hDEAD;
   end

   task automatic checkOutput(input string name, input logic [63:0] actual,
                              input logic [63:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   // Monitor: samples 1 unit after each falling edge, compares against the
   // model, then advances the model by what the coming rising edge will do.
   initial begin
      int          outstanding;
      bit          exp_in_ready, exp_out_valid, exp_done;
      bit          prev_stall;
      logic [15:0] prev_w, prev_a;
      logic        prev_last;
      exp_t        e;
      prev_stall = 1'b0;
      prev_w = '0;
      prev_a = '0;
      prev_last = 1'b0;
      forever begin
         @(negedge clk);
         #1;
         if (rst) begin
            checkOutput("reset_outputs",
                        {busy, done, in_ready, rom_ren, rom_radd, out_valid,
                         out_weight, out_act, out_last}, 64'd0);
            m_active = 0;
            m_acc = 0;
            m_taken = 0;
            exp_q.delete();
            prev_stall = 1'b0;
         end else begin
            outstanding   = m_acc - m_taken;
            exp_in_ready  = (m_active != 0) && (m_acc < NW) && (outstanding < 2);
            exp_out_valid = (outstanding > 0);
            exp_done      = (m_active != 0) && (m_acc == NW) && (outstanding == 0);
            checkOutput("in_ready", in_ready, exp_in_ready);
            checkOutput("out_valid", out_valid, exp_out_valid);
            checkOutput("busy", busy, m_active != 0);
            checkOutput("done", done, exp_done);
            if (done) dut_done_count++;
            if (prev_stall) begin
               checkOutput("hold_weight", out_weight, prev_w);
               checkOutput("hold_act", out_act, prev_a);
               checkOutput("hold_last", out_last, prev_last);
            end
            if (in_valid && exp_in_ready) begin
               checkOutput("rom_ren_on_accept", rom_ren, 1);
               checkOutput("rom_radd", rom_radd, m_acc);
               e.w = mem[m_acc];
               e.a = in_data;
               e.last = (m_acc == NW - 1);
               exp_q.push_back(e);
               m_acc++;
            end else begin
               checkOutput("rom_ren_no_accept", rom_ren, 0);
            end
            if (exp_out_valid && out_ready) begin
               if (out_valid && out_last) dut_last_count++;
               if (exp_q.size() == 0) begin
                  checkOutput("scoreboard_empty", 1, 0);
               end else begin
                  e = exp_q.pop_front();
                  checkOutput("out_weight", out_weight, e.w);
                  checkOutput("out_act", out_act, e.a);
                  checkOutput("out_last", out_last, e.last);
               end
               m_taken++;
            end
            prev_stall = exp_out_valid && !out_ready;
            prev_w = out_weight;
            prev_a = out_act;
            prev_last = out_last;
            if (exp_done) begin
               m_active = 0;
               done_count++;
            end else if ((m_active == 0) && start) begin
               m_active = 1;
               m_acc = 0;
               m_taken = 0;
            end
         end
      end
   end

   // Drives one pass. mode 0: steady; 1: MAC stall cycles 3-10;
   // 2: random in_valid; 3: start held from pair 12 until the cycle after
   // done; 4: reset at pair 17 with the FIFO full; 5: random both sides.
   task automatic applyStimulus(input int mode, input bit do_start);
      int cyc = 0;
      int stall = 0;
      int base_done = done_count;
      bit fin = 1'b0;
      while (!fin) begin
         @(negedge clk);
         if (done_count != base_done) begin
            start    = (mode == 3);
            in_valid = 1'b0;
            fin      = 1'b1;
         end else begin
            start    = (do_start && (cyc == 0)) || ((mode == 3) && (m_taken >= 12));
            in_valid = ((mode == 2) || (mode == 5)) ? 1'($urandom_range(0, 1)) : 1'b1;
            in_data  = 16'($urandom);
            case (mode)
               1:       out_ready = !((cyc >= 3) && (cyc <= 10));
               4:       out_ready = (m_taken < 17);
               5:       out_ready = ($urandom_range(0, 3) != 0);
               default: out_ready = 1'b1;
            endcase
            if ((mode == 4) && !out_ready) begin
               stall++;
               if (stall == 6) begin
                  rst = 1'b1;
                  fin = 1'b1;
               end
            end
         end
         cyc++;
         if (!fin && (cyc > 800)) begin
            checks++;
            errors++;
            $display("[TB] FAIL pass_timeout: mode %0d, no done after %0d cycles", mode, cyc);
            fin = 1'b1;
         end
      end
      if (mode == 4) begin
         repeat (2) @(negedge clk);
         rst = 1'b0;
         start = 1'b0;
         in_valid = 1'b0;
         out_ready = 1'b1;
      end
   endtask

   initial begin
      rst = 1'b1;
      start = 1'b0;
      in_valid = 1'b0;
      in_data = '0;
      out_ready = 1'b1;
      start1 = 1'b0;
      in_valid1 = 1'b0;
      in_data1 = '0;
      out_ready1 = 1'b1;
      for (int i = 0; i < NW; i++) mem[i] = 16'(i + 100);
      repeat (3) @(negedge clk);
      rst = 1'b0;

      $display("[TB] T1 steady pass");
      applyStimulus(0, 1'b1);
      for (int i = 0; i < NW; i++) mem[i] = 16'($urandom);
      $display("[TB] T2 MAC stall");
      applyStimulus(1, 1'b1);
      $display("[TB] T3 random in_valid");
      applyStimulus(2, 1'b1);
      applyStimulus(5, 1'b1);
      $display("[TB] T4 start mid-pass and right after done");
      applyStimulus(3, 1'b1);
      applyStimulus(0, 1'b0);
      $display("[TB] T5 reset mid-pass");
      applyStimulus(4, 1'b1);
      applyStimulus(0, 1'b1);

      checkOutput("done_pulses", dut_done_count, 7);
      checkOutput("last_pairs", dut_last_count, 7);

      $display("[TB] T6 single-weight build");
      @(negedge clk);
      start1 = 1'b1;
      #1;
      checkOutput("nw1_idle_busy", busy1, 0);
      @(negedge clk);
      start1 = 1'b0;
      in_valid1 = 1'b1;
      in_data1 = 16'h1234;
      #1;
      checkOutput("nw1_accept", {busy1, in_ready1, rom_ren1, rom_radd1}, 4'b1110);
      @(negedge clk);
      in_valid1 = 1'b0;
      #1;
      checkOutput("nw1_pair", {out_valid1, out_weight1, out_act1, out_last1},
                  {1'b1, 16'h55AA, 16'h1234, 1'b1});
      checkOutput("nw1_no_second_read", {in_ready1, rom_ren1, done1}, 3'b000);
      @(negedge clk);
      #1;
      checkOutput("nw1_done", {done1, out_valid1, busy1}, 3'b101);
      @(negedge clk);
      #1;
      checkOutput("nw1_idle_after", {done1, busy1}, 2'b00);

      repeat (2) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
